lcd_read_port: RTL and testbench
================================

# lcd_read_port

Read-side engine for the 4-bit HD44780-style character LCD bus. It issues one read transaction per request, with RW=1 and RS selecting either busy-flag/address or data RAM. It strobes E twice and assembles the two returned nibbles, upper nibble first, into one byte. It sits beside the LCD write/init controller, which polls it for the busy flag instead of waiting fixed worst-case delays.

## Interface
Parameters:
- SETUP_CYCLES, 4: cycles RS/RW are stable before E rises, and also the hold time after E falls (tAS/tAH at 50 MHz).
- E_HIGH_CYCLES, 12: E pulse width per nibble (≥230 ns).
- GAP_CYCLES, 50: E-low time between the two nibbles (≥1 µs).
- MAX_POLLS, 1024: read attempts before poll timeout. Only used with LCD_BUSY_POLL_EN.

Ports:
- Clock, in, 1: system clock, 50 MHz.
- Reset, in, 1: synchronous, active-high.
- iStart, in, 1: request a read. Sampled only while oReady=1.
- iRS, in, 1: 0 = status/address read, 1 = data RAM read. Latched at start.
- iPoll, in, 1: busy-poll request. Ignored without LCD_BUSY_POLL_EN.
- SF_DATA_IN, in, 4: LCD data bus as seen by the FPGA.
- oReady, out, 1: idle and able to accept iStart.
- oDone, out, 1: one-cycle pulse when the transaction ends.
- oData, out, 8: assembled byte, held until the next accepted start.
- oTimeout, out, 1: valid with oDone. 1 = poll limit reached.
- oBusRequest, out, 1: 1 while a transaction owns the LCD pins; the FPGA bus drivers must be tri-stated.
- LCD_E, out, 1: enable strobe.
- LCD_RS, out, 1: register select.
- LCD_RW, out, 1: 1 = read.

## Operation
- Reset values: LCD_E=0, LCD_RW=0, LCD_RS=0, oBusRequest=0, oDone=0, oTimeout=0, oData=8'h00, oReady=1. State is IDLE.
- States: IDLE → SETUP → E_HI_H → GAP → E_HI_L → HOLD → DONE → IDLE.
- IDLE: oReady=1. If iStart=1, latch iRS (forced to 0 when poll is active), clear the poll count, and go to SETUP.
- SETUP: LCD_RW=1, LCD_RS=latched value, LCD_E=0.
- E_HI_H: LCD_E=1. On the last cycle of this state, sample SF_DATA_IN into oData[7:4].
- GAP: LCD_E=0.
- E_HI_L: LCD_E=1. On the last cycle, sample SF_DATA_IN into oData[3:0].
- HOLD: LCD_E=0, LCD_RW remains 1.
- DONE: LCD_RW=0, oDone=1, oBusRequest=0, oReady=0. The next cycle is IDLE.
- oBusRequest=1 from SETUP through HOLD.
- While not in IDLE, iStart is ignored; requests are neither queued nor counted.
- A single down-counter is reloaded on every state entry; each timed state exits when the counter reaches 0.
- Reset in any state returns the block to IDLE on the next edge with reset values. oData is cleared, and no oDone is issued.

## Timing
- With iStart accepted at edge 0 and default parameters:
  - SETUP: cycles 1–4.
  - E_HI_H: cycles 5–16; upper nibble sampled in cycle 16.
  - GAP: cycles 17–66.
  - E_HI_L: cycles 67–78; lower nibble sampled in cycle 78.
  - HOLD: cycles 79–82.
  - oDone: cycle 83.
  - oReady: returns in cycle 84.
- General latency to oDone: 2·SETUP_CYCLES + 2·E_HIGH_CYCLES + GAP_CYCLES + 1.
- LCD_RS changes only while LCD_E=0 and LCD_RW=0.
- LCD_RW changes only while LCD_E=0.

## Configuration
- LCD_BUSY_POLL_EN defined:
  - A start with iPoll=1 forces RS=0.
  - At the end of HOLD, if oData[7]=1 and the poll count is below MAX_POLLS−1, increment the count and return to GAP (RW stays 1); otherwise go to DONE.
  - oTimeout=1 when DONE is reached with oData[7]=1.
  - oData always holds the last status read.
- LCD_BUSY_POLL_EN undefined:
  - iPoll is ignored and oTimeout is tied to 0.
  - The poll counter is not built.
  - Every transaction is a single read.

## Structure
- Shared package lcd_pkg holds:
  - State encodings for this block's state machine.
  - Default timing constants, shared with the LCD write controller so both use one timing set.
  - The LCD_RS encodings RS_CMD=0 and RS_DATA=1.
- One sub-module: lcd_delay_counter, a loadable down-counter with a terminal-count flag and a synchronous reset.

## Test plan
- Reset, then idle for 10 cycles → all outputs at reset values, oReady=1, no E activity.
- iStart with iRS=1; SF_DATA_IN=4'hA during the first E pulse and 4'h5 during the second → oData=8'hA5, oDone exactly in cycle 83, LCD_RS=1 and LCD_RW=1 for cycles 1–82.
- Measure pulse widths → E high exactly 12 cycles twice, E low between pulses exactly 50 cycles, RW=1 for 4 cycles before the first E rise and 4 cycles after the last E fall.
- Poll mode (LCD_BUSY_POLL_EN, MAX_POLLS=1024): LCD model returns 8'h80 on three reads, then 8'h0C → four E-pulse pairs, oData=8'h0C, oTimeout=0, one oDone.
- Poll timeout (MAX_POLLS=4, busy flag stuck at 8'hFF) → exactly four reads, then oDone with oTimeout=1 and oData=8'hFF.
- Reset at cycle 30 of a read, plus iStart pulses at cycles 10 and 20 of a separate read → after reset, E=0, RW=0, oReady=1 next cycle, no oDone. The mid-read iStart pulses produce no extra transaction.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD bus encodings and timing defaults
// Holds the read-engine state encoding, the timing set shared with the
// LCD write controller (50 MHz clock), and the LCD_RS register-select codes.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_E_HI_H = 3'd2,
    ST_GAP    = 3'd3,
    ST_E_HI_L = 3'd4,
    ST_HOLD   = 3'd5,
    ST_DONE   = 3'd6
  } rd_state_t;

  localparam int LCD_SETUP_CYCLES  = 4;
  localparam int LCD_E_HIGH_CYCLES = 12;
  localparam int LCD_GAP_CYCLES    = 50;
  localparam int LCD_MAX_POLLS     = 1024;

  // Width of the shared delay counter; covers every timing constant above.
  localparam int LCD_CNT_W = 16;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_delay_counter.sv
// rtl/lcd_delay_counter.sv - loadable down-counter with terminal-count flag
// Ports: clk, rst (sync, active-high), load/load_value (reload, wins over
// counting), tc (count is zero). Counting stops at zero.
module lcd_delay_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/lcd_read_port.sv
// rtl/lcd_read_port.sv - 4-bit HD44780 read engine (two E strobes per byte)
// Ports: Clock, Reset (sync, active-high); iStart/iRS/iPoll request inputs;
// SF_DATA_IN LCD data bus; oReady/oDone/oData/oTimeout results;
// oBusRequest (FPGA bus drivers must tri-state); LCD_E/LCD_RS/LCD_RW pins.
// Optional feature macro: LCD_BUSY_POLL_EN (busy-flag polling loop).
module lcd_read_port
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES  = LCD_SETUP_CYCLES,
  parameter int E_HIGH_CYCLES = LCD_E_HIGH_CYCLES,
  parameter int GAP_CYCLES    = LCD_GAP_CYCLES,
  parameter int MAX_POLLS     = LCD_MAX_POLLS
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  input  logic [3:0] SF_DATA_IN,
  output logic       oReady,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       oTimeout,
  output logic       oBusRequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  localparam int CW = LCD_CNT_W;

  rd_state_t       state;
  logic            cnt_load;
  logic [CW-1:0]   cnt_value;
  logic            cnt_tc;
  logic            hi_nibble_done;  // selects which E pulse follows GAP
  logic            start_rs;
  logic            poll_again;

  lcd_delay_counter #(.WIDTH(CW)) u_delay (
    .clk        (Clock),
    .rst        (Reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .tc         (cnt_tc)
  );

`ifdef LCD_BUSY_POLL_EN
  localparam int PW = $clog2(MAX_POLLS + 1);
  logic [PW-1:0] poll_cnt;
  logic          poll_q;
  logic          timeout_q;

  assign start_rs   = iPoll ? RS_CMD : iRS;
  // Only a transaction started as a poll loops on the busy flag.
  assign poll_again = poll_q && oData[7] && (poll_cnt < PW'(MAX_POLLS - 1));
  assign oTimeout   = timeout_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      poll_q    <= 1'b0;
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && iStart) begin
        poll_q   <= iPoll;
        poll_cnt <= '0;
      end else if (state == ST_HOLD && cnt_tc && poll_again) begin
        poll_cnt <= poll_cnt + 1'b1;
      end
      if (state == ST_HOLD && cnt_tc) begin
        timeout_q <= poll_q && oData[7] && !poll_again;
      end else if (state == ST_DONE) begin
        timeout_q <= 1'b0;
      end
    end
  end
`else
  logic unused_poll;
  assign unused_poll = iPoll | (MAX_POLLS == 0);
  assign start_rs    = iRS;
  assign poll_again  = 1'b0;
  assign oTimeout    = 1'b0;
`endif

  // The counter is reloaded on the same edge that enters the next state,
  // so the reload value is the duration of the state being entered, minus 1.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      ST_IDLE: begin
        cnt_load  = iStart;
        cnt_value = CW'(SETUP_CYCLES - 1);
      end
      ST_SETUP: begin
        cnt_load  = cnt_tc;
        cnt_value = CW'(E_HIGH_CYCLES - 1);
      end
      ST_E_HI_H: begin
        cnt_load  = cnt_tc;
        cnt_value = CW'(GAP_CYCLES - 1);
      end
      ST_GAP: begin
        cnt_load  = cnt_tc;
        cnt_value = CW'(E_HIGH_CYCLES - 1);
      end
      ST_E_HI_L: begin
        cnt_load  = cnt_tc;
        cnt_value = CW'(SETUP_CYCLES - 1);
      end
      ST_HOLD: begin
        cnt_load  = cnt_tc;
        cnt_value = CW'(GAP_CYCLES - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= ST_IDLE;
      LCD_E          <= 1'b0;
      LCD_RW         <= 1'b0;
      LCD_RS         <= RS_CMD;
      oBusRequest    <= 1'b0;
      oDone          <= 1'b0;
      oReady         <= 1'b1;
      oData          <= 8'h00;
      hi_nibble_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state          <= ST_SETUP;
            oReady         <= 1'b0;
            LCD_RW         <= 1'b1;
            LCD_RS         <= start_rs;
            oBusRequest    <= 1'b1;
            hi_nibble_done <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cnt_tc) begin
            state <= ST_E_HI_H;
            LCD_E <= 1'b1;
          end
        end
        ST_E_HI_H: begin
          if (cnt_tc) begin
            state          <= ST_GAP;
            LCD_E          <= 1'b0;
            oData[7:4]     <= SF_DATA_IN;
            hi_nibble_done <= 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_tc) begin
            state <= hi_nibble_done ? ST_E_HI_L : ST_E_HI_H;
            LCD_E <= 1'b1;
          end
        end
        ST_E_HI_L: begin
          if (cnt_tc) begin
            state          <= ST_HOLD;
            LCD_E          <= 1'b0;
            oData[3:0]     <= SF_DATA_IN;
            hi_nibble_done <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (cnt_tc) begin
            if (poll_again) begin
              // Re-read status without dropping RW; GAP gives the E-low time.
              state <= ST_GAP;
            end else begin
              state       <= ST_DONE;
              LCD_RW      <= 1'b0;
              oBusRequest <= 1'b0;
              oDone       <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          oDone  <= 1'b0;
          oReady <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_read_port.sv
// tb/tb_lcd_read_port.sv - randomized self-checking bench for lcd_read_port
module tb_lcd_read_port;
  import lcd_pkg::*;

  localparam int S   = 4;
  localparam int EH  = 12;
  localparam int G   = 50;
`ifdef LCD_BUSY_POLL_EN
  localparam int MP  = 4;
`else
  localparam int MP  = 1024;
`endif
  localparam int LAT  = 2 * S + 2 * EH + G + 1;
  localparam int MAXC = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rs_in = 1'b0;
  logic       poll = 1'b0;
  logic [3:0] sf = 4'h0;
  logic       ready, done, timeout, busreq, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] data;

  always #5 clk = ~clk;

  lcd_read_port #(
    .SETUP_CYCLES (S),
    .E_HIGH_CYCLES(EH),
    .GAP_CYCLES   (G),
    .MAX_POLLS    (MP)
  ) dut (
    .Clock      (clk),
    .Reset      (rst),
    .iStart     (start),
    .iRS        (rs_in),
    .iPoll      (poll),
    .SF_DATA_IN (sf),
    .oReady     (ready),
    .oDone      (done),
    .oData      (data),
    .oTimeout   (timeout),
    .oBusRequest(busreq),
    .LCD_E      (lcd_e),
    .LCD_RS     (lcd_rs),
    .LCD_RW     (lcd_rw)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle capture; index k is the cycle after edge k-1 (edge 0 accepts start).
  logic       e_s[0:MAXC], rw_s[0:MAXC], rs_s[0:MAXC], done_s[0:MAXC];
  logic       rdy_s[0:MAXC], br_s[0:MAXC], to_s[0:MAXC];
  logic [7:0] data_s[0:MAXC];
  logic [7:0] byte_q[$];  // bytes the LCD model returns, one per read

  task automatic run_txn(input logic rs, input logic pl, input int ncyc,
                         input int rst_at, input bit noise);
    int pulses;
    int idx;
    logic [7:0] b;
    pulses = 0;
    @(negedge clk);
    e_s[0] = lcd_e; rw_s[0] = lcd_rw; rs_s[0] = lcd_rs; done_s[0] = done;
    rdy_s[0] = ready; br_s[0] = busreq; to_s[0] = timeout; data_s[0] = data;
    start = 1'b1; rs_in = rs; poll = pl;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      e_s[k] = lcd_e; rw_s[k] = lcd_rw; rs_s[k] = lcd_rs; done_s[k] = done;
      rdy_s[k] = ready; br_s[k] = busreq; to_s[k] = timeout; data_s[k] = data;
      if (lcd_e && !e_s[k-1]) pulses++;
      if (lcd_e) begin
        idx = (pulses - 1) / 2;
        if (idx >= byte_q.size()) idx = byte_q.size() - 1;
        b  = byte_q[idx];
        sf = (pulses % 2 == 1) ? b[7:4] : b[3:0];
      end else begin
        sf = 4'($urandom);
      end
      start = noise && (k == 10 || k == 20);
      rst   = (k == rst_at);
      if (k == 1) begin
        rs_in = 1'($urandom);
        poll  = 1'($urandom);
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  int n_rise, done_cnt, first_done, rw_first, rw_last, rw_cnt;
  int rs_bad, rs_viol, rw_viol, rdy_cnt, br_cnt;
  int rise_at[8], fall_at[8];

  task automatic analyze(input int ncyc, input logic exp_rs);
    n_rise = 0; done_cnt = 0; first_done = 0; rw_first = -1; rw_last = -1;
    rw_cnt = 0; rs_bad = 0; rs_viol = 0; rw_viol = 0; rdy_cnt = 0; br_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rise_at[i] = 0;
      fall_at[i] = 0;
    end
    for (int k = 1; k <= ncyc; k++) begin
      if (e_s[k] && !e_s[k-1]) begin
        if (n_rise < 8) rise_at[n_rise] = k;
        n_rise++;
      end
      if (!e_s[k] && e_s[k-1] && n_rise > 0 && n_rise <= 8) fall_at[n_rise-1] = k;
      if (done_s[k]) begin
        if (done_cnt == 0) first_done = k;
        done_cnt++;
      end
      if (rw_s[k]) begin
        if (rw_first < 0) rw_first = k;
        rw_last = k;
        rw_cnt++;
        if (rs_s[k] !== exp_rs) rs_bad++;
      end
      if (rw_s[k] !== rw_s[k-1] && (e_s[k] || e_s[k-1])) rw_viol++;
      if (rs_s[k] !== rs_s[k-1] && (e_s[k-1] || rw_s[k-1])) rs_viol++;
      if (k <= LAT && rdy_s[k]) rdy_cnt++;
      if (br_s[k]) br_cnt++;
    end
  endtask

  // Single read: checks byte assembly and every timing rule against the formulas.
  task automatic single_read(input logic rs, input logic [3:0] hi, input logic [3:0] lo);
    int ncyc;
    ncyc = LAT + 30;
    byte_q.delete();
    byte_q.push_back({hi, lo});
    run_txn(rs, 1'b0, ncyc, 0, 1'b0);
    analyze(ncyc, rs);
    check_eq("data", data_s[ncyc], {hi, lo});
    check_eq("done_count", done_cnt, 1);
    check_eq("done_cycle", first_done, LAT);
    check_eq("e_pulses", n_rise, 2);
    check_eq("first_e_rise", rise_at[0], S + 1);
    check_eq("e_width_1", fall_at[0] - rise_at[0], EH);
    check_eq("e_gap", rise_at[1] - fall_at[0], G);
    check_eq("e_width_2", fall_at[1] - rise_at[1], EH);
    check_eq("rw_first", rw_first, 1);
    check_eq("rw_last", rw_last, LAT - 1);
    check_eq("rw_count", rw_cnt, LAT - 1);
    check_eq("rs_during_read", rs_bad, 0);
    check_eq("rw_setup", rise_at[0] - rw_first, S);
    check_eq("rw_hold", rw_last + 1 - fall_at[1], S);
    check_eq("ready_busy", rdy_cnt, 0);
    check_eq("ready_return", rdy_s[LAT + 1], 1);
    check_eq("busreq_count", br_cnt, LAT - 1);
    check_eq("rs_change_rule", rs_viol, 0);
    check_eq("rw_change_rule", rw_viol, 0);
    check_eq("timeout_at_done", to_s[LAT], 0);
  endtask

  int idle_bad;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_eq("reset_ready", ready, 1);
    check_eq("reset_data", data, 8'h00);
    check_eq("reset_e", lcd_e, 0);
    idle_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (lcd_e || lcd_rw || lcd_rs || busreq || done || timeout || data != 8'h00 || !ready)
        idle_bad++;
    end
    check_eq("idle_outputs", idle_bad, 0);

    single_read(RS_DATA, 4'hA, 4'h5);
    for (int t = 0; t < 4; t++) begin
      single_read(1'($urandom), 4'($urandom), 4'($urandom));
    end

    // iStart pulses mid-read must neither restart nor queue a transaction.
    byte_q.delete();
    byte_q.push_back(8'($urandom));
    run_txn(RS_CMD, 1'b0, LAT + 100, 0, 1'b1);
    analyze(LAT + 100, RS_CMD);
    check_eq("noise_done_count", done_cnt, 1);
    check_eq("noise_done_cycle", first_done, LAT);
    check_eq("noise_e_pulses", n_rise, 2);
    check_eq("noise_data", data_s[LAT + 100], byte_q[0]);

    // Reset asserted during cycle 30 (GAP): clean return, no oDone.
    byte_q.delete();
    byte_q.push_back(8'hC3);
    run_txn(RS_DATA, 1'b0, 130, 30, 1'b0);
    analyze(130, RS_DATA);
    check_eq("rst_e", e_s[31], 0);
    check_eq("rst_rw", rw_s[31], 0);
    check_eq("rst_ready", rdy_s[31], 1);
    check_eq("rst_busreq", br_s[31], 0);
    check_eq("rst_data", data_s[31], 8'h00);
    check_eq("rst_no_done", done_cnt, 0);
    check_eq("rst_e_pulses", n_rise, 1);

    single_read(RS_DATA, 4'h3, 4'hE);

`ifdef LCD_BUSY_POLL_EN
    // Busy three times then clear: reads = busy count + 1.
    byte_q.delete();
    byte_q.push_back(8'h80); byte_q.push_back(8'h80);
    byte_q.push_back(8'h80); byte_q.push_back(8'h0C);
    run_txn(RS_DATA, 1'b1, 600, 0, 1'b0);
    analyze(600, RS_CMD);
    check_eq("poll_e_pulses", n_rise, 8);
    check_eq("poll_data", data_s[600], 8'h0C);
    check_eq("poll_done_count", done_cnt, 1);
    check_eq("poll_timeout", to_s[first_done], 0);
    check_eq("poll_rs", rs_bad, 0);

    // Busy stuck: exactly MAX_POLLS reads, then timeout.
    byte_q.delete();
    byte_q.push_back(8'hFF);
    run_txn(RS_DATA, 1'b1, 600, 0, 1'b0);
    analyze(600, RS_CMD);
    check_eq("stuck_e_pulses", n_rise, 2 * MP);
    check_eq("stuck_data", data_s[600], 8'hFF);
    check_eq("stuck_done_count", done_cnt, 1);
    check_eq("stuck_timeout", to_s[first_done], 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
